// File: rtl/instr_encoder_if.sv
// Encode-request channel for instr_encoder: valid/ready handshake plus
// the op select and operand fields. master drives requests, slave accepts.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    modport master (
        output in_valid,
        output in_op,
        output in_rs,
        output in_rt,
        output in_rd,
        output in_imm,
        output in_target,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_rs,
        input  in_rt,
        input  in_rd,
        input  in_imm,
        input  in_target,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns op/field requests into 32-bit instruction words and
// writes them to consecutive instruction-memory addresses from BASE_ADDR.
// Ports: clk, rst (sync, active-high), clear (sync restart), req (slave
// request channel), im_we/im_addr/im_wdata (registered write bus),
// count (words written), full (count==DEPTH), err (sticky illegal op).
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    instr_encoder_if.slave       req,
    output logic                 im_we,
    output logic [31:0]          im_addr,
    output logic [31:0]          im_wdata,
    output logic [10:0]          count,
    output logic                 full,
    output logic                 err
);

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    localparam logic [5:0] OP_ADDU  = 6'd0;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] OPC_ORI  = 6'h0D;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_LUI  = 6'h0F;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_ADDU = 6'h09;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_JAL  = 6'h03;

    typedef enum logic {
        IDLE = 1'b0,
        WR   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [10:0] count_q, count_d;
    logic        err_q, err_d;

    logic        full_w;
    logic        ready_w;
    logic        accept;
    logic        legal;
    logic [31:0] enc_word;
    logic [31:0] next_addr;

    assign full_w  = (count_q == DEPTH_W);
    assign ready_w = (state_q == IDLE) & ~full_w & ~clear & ~rst;
    assign accept  = req.in_valid & ready_w;

    assign next_addr = BASE_ADDR + {19'd0, count_q, 2'b00};

    // Field packing for the three word formats.
    always_comb begin
        enc_word = 32'd0;
        legal    = 1'b1;
        unique case (req.in_op)
            4'd0: enc_word = {OP_ADDU, req.in_rs, req.in_rt,
                              req.in_rd, 5'd0, F_ADDU};
            4'd1: enc_word = {OP_ADDU, req.in_rs, req.in_rt,
                              req.in_rd, 5'd0, F_SUBU};
            4'd2: enc_word = {OP_ADDU, req.in_rs, req.in_rt,
                              req.in_rd, 5'd0, F_SLT};
            4'd3: enc_word = {OP_ADDU, req.in_rs, 5'd0,
                              5'd0, 5'd0, F_JR};
            4'd4: enc_word = {OPC_ORI, req.in_rs, req.in_rt,
                              req.in_imm};
            4'd5: enc_word = {OPC_LW, req.in_rs, req.in_rt,
                              req.in_imm};
            4'd6: enc_word = {OPC_SW, req.in_rs, req.in_rt,
                              req.in_imm};
            4'd7: enc_word = {OPC_BEQ, req.in_rs, req.in_rt,
                              req.in_imm};
            4'd8: enc_word = {OPC_LUI, 5'd0, req.in_rt,
                              req.in_imm};
            4'd9: enc_word = {OPC_J, req.in_target};
            4'd10: enc_word = {OPC_ADDI, req.in_rs, req.in_rt,
                               req.in_imm};
            4'd11: enc_word = {OPC_ADDU, req.in_rs, req.in_rt,
                               req.in_imm};
            4'd12: enc_word = {OPC_JAL, req.in_target};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = 11'd0;
                    err_d   = 1'b0;
                end else if (accept) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        addr_d  = next_addr;
                        wdata_d = enc_word;
                        state_d = WR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR: begin
                // The strobe already on the bus completes; clear only
                // discards the pending increment.
                state_d = IDLE;
                if (clear) begin
                    count_d = 11'd0;
                    err_d   = 1'b0;
                end else begin
                    count_d = count_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            count_q <= 11'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign req.in_ready = ready_w;
    assign im_we        = we_q;
    assign im_addr      = addr_q;
    assign im_wdata     = wdata_q;
    assign count        = count_q;
    assign full         = full_w;
    assign err          = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand
// sequences for clear/rst/full corners, and randomized model comparison.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, valid;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;

    instr_encoder_if ifa();
    instr_encoder_if ifb();

    assign ifa.in_valid  = valid;
    assign ifa.in_op     = op;
    assign ifa.in_rs     = rs;
    assign ifa.in_rt     = rt;
    assign ifa.in_rd     = rd;
    assign ifa.in_imm    = imm;
    assign ifa.in_target = tgt;
    assign ifb.in_valid  = valid;
    assign ifb.in_op     = op;
    assign ifb.in_rs     = rs;
    assign ifb.in_rt     = rt;
    assign ifb.in_rd     = rd;
    assign ifb.in_imm    = imm;
    assign ifb.in_target = tgt;

    logic        we_a, we_b, full_a, full_b, err_a, err_b;
    logic [31:0] addr_a, addr_b, wd_a, wd_b;
    logic [10:0] cnt_a, cnt_b;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(1024)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .req(ifa),
        .im_we(we_a), .im_addr(addr_a), .im_wdata(wd_a),
        .count(cnt_a), .full(full_a), .err(err_a)
    );

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .req(ifb),
        .im_we(we_b), .im_addr(addr_b), .im_wdata(wd_b),
        .count(cnt_b), .full(full_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] word;
    } vec_t;

    vec_t tv[15];

    // Reference encoder built from the format rules with plain arithmetic.
    function automatic logic [31:0] ref_word(input int o, input int s,
        input int t, input int d, input int i, input int g);
        int fn[4];
        int opc[13];
        fn  = '{'h21, 'h23, 'h2A, 'h08};
        opc = '{0, 0, 0, 0, 'h0D, 'h23, 'h2B, 'h04, 'h0F, 'h02,
                'h08, 'h09, 'h03};
        if (o <= 3) begin
            if (o == 3) begin t = 0; d = 0; end
            return 32'(s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + fn[o]);
        end
        if (o == 9 || o == 12)
            return 32'(opc[o] * (1 << 26) + g);
        if (o == 8) s = 0;
        return 32'(opc[o] * (1 << 26) + s * (1 << 21) + t * (1 << 16) + i);
    endfunction

    task automatic idle_inputs();
        valid = 1'b0; op = 4'd0; rs = '0; rt = '0; rd = '0;
        imm = '0; tgt = '0;
    endtask

    task automatic set_req(input logic [3:0] o, input logic [4:0] s,
                           input logic [4:0] t, input logic [4:0] d);
        valid = 1'b1; op = o; rs = s; rt = t; rd = d;
    endtask

    int          mcnt[2], dep[2];
    bit          mbusy[2], mwe[2], merr[2];
    logic [31:0] maddr[2], mword[2];
    int          exp_cnt;
    bit          exp_rdy;

    initial begin
        tv[0]  = '{4'd0,  5'd1,  5'd2,  5'd3, 16'h0000, 26'h0, 32'h0022_1821};
        tv[1]  = '{4'd4,  5'd0,  5'd8,  5'd0, 16'h1234, 26'h0, 32'h3408_1234};
        tv[2]  = '{4'd8,  5'd5,  5'd1,  5'd0, 16'hABCD, 26'h0, 32'h3C01_ABCD};
        tv[3]  = '{4'd9,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h0000C00, 32'h0800_0C00};
        tv[4]  = '{4'd3,  5'd31, 5'd7,  5'd9, 16'h0000, 26'h0, 32'h03E0_0008};
        tv[5]  = '{4'd14, 5'd1,  5'd1,  5'd1, 16'h0000, 26'h0, 32'h0};
        tv[6]  = '{4'd1,  5'd4,  5'd5,  5'd6, 16'h0000, 26'h0, 32'h0085_3023};
        tv[7]  = '{4'd2,  5'd7,  5'd8,  5'd9, 16'h0000, 26'h0, 32'h00E8_482A};
        tv[8]  = '{4'd5,  5'd2,  5'd3,  5'd0, 16'h0010, 26'h0, 32'h8C43_0010};
        tv[9]  = '{4'd6,  5'd29, 5'd31, 5'd0, 16'hFFFC, 26'h0, 32'hAFBF_FFFC};
        tv[10] = '{4'd7,  5'd1,  5'd2,  5'd0, 16'hFFFF, 26'h0, 32'h1022_FFFF};
        tv[11] = '{4'd10, 5'd3,  5'd4,  5'd0, 16'h8000, 26'h0, 32'h2064_8000};
        tv[12] = '{4'd11, 5'd0,  5'd1,  5'd0, 16'h0001, 26'h0, 32'h2401_0001};
        tv[13] = '{4'd12, 5'd0,  5'd0,  5'd0, 16'h0000, 26'h3FFFFFF, 32'h0FFF_FFFF};
        tv[14] = '{4'd15, 5'd2,  5'd2,  5'd2, 16'h0000, 26'h0, 32'h0};

        rst = 1'b1; clear = 1'b0; idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_addr", addr_a, 32'd0);
        check("rst_wdata", wd_a, 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_ready", 32'(ifa.in_ready), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("ready_after_rst", 32'(ifa.in_ready), 32'd1);

        exp_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            set_req(tv[i].op, tv[i].rs, tv[i].rt, tv[i].rd);
            imm = tv[i].imm; tgt = tv[i].tgt;
            #1 check("tv_ready", 32'(ifa.in_ready), 32'd1);
            @(posedge clk);
            #1;
            if (tv[i].op <= 4'd12) begin
                check("tv_we", 32'(we_a), 32'd1);
                check("tv_addr", addr_a, BASE + 32'(4 * exp_cnt));
                check("tv_wdata", wd_a, tv[i].word);
                check("tv_ready_wr", 32'(ifa.in_ready), 32'd0);
                @(negedge clk) valid = 1'b0;
                @(posedge clk);
                #1;
                exp_cnt++;
                check("tv_we_drop", 32'(we_a), 32'd0);
                check("tv_count", 32'(cnt_a), 32'(exp_cnt));
            end else begin
                check("ill_we", 32'(we_a), 32'd0);
                check("ill_err", 32'(err_a), 32'd1);
                check("ill_count", 32'(cnt_a), 32'(exp_cnt));
                @(negedge clk) valid = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("hold_addr", addr_a, BASE + 32'(4 * (exp_cnt - 1)));
        check("hold_wdata", wd_a, 32'h0FFF_FFFF);
        check("err_sticky", 32'(err_a), 32'd1);

        @(negedge clk);
        clear = 1'b1; set_req(4'd0, 5'd1, 5'd2, 5'd3);
        #1 check("clr_ready", 32'(ifa.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("clr_err", 32'(err_a), 32'd0);
        check("clr_count", 32'(cnt_a), 32'd0);
        check("clr_no_take", 32'(we_a), 32'd0);
        @(negedge clk) clear = 1'b0;
        @(posedge clk);
        #1 check("rst_wr_pre", 32'(we_a), 32'd1);
        @(negedge clk) begin rst = 1'b1; valid = 1'b0; end
        @(posedge clk);
        #1;
        check("rst_wr_we", 32'(we_a), 32'd0);
        check("rst_wr_count", 32'(cnt_a), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("rst_wr_idle", 32'(ifa.in_ready), 32'd1);
        set_req(4'd0, 5'd1, 5'd2, 5'd3);
        @(posedge clk);
        @(negedge clk) begin clear = 1'b1; valid = 1'b0; end
        #1 check("clr_wr_we", 32'(we_a), 32'd1);
        @(posedge clk);
        #1;
        check("clr_wr_count", 32'(cnt_a), 32'd0);
        check("clr_wr_we_off", 32'(we_a), 32'd0);
        @(negedge clk) clear = 1'b0;
        #1 check("clr_wr_idle", 32'(ifa.in_ready), 32'd1);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin rst = 1'b0; set_req(4'd0, 5'd1, 5'd2, 5'd3); end
        repeat (8) @(posedge clk);
        #1;
        check("d4_count", 32'(cnt_b), 32'd4);
        check("d4_full", 32'(full_b), 32'd1);
        check("d4_ready", 32'(ifb.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("d4_no_wr", 32'(we_b), 32'd0);
        check("d4_hold", 32'(cnt_b), 32'd4);
        check("d4_last_addr", addr_b, BASE + 32'd12);
        @(negedge clk) clear = 1'b1;
        @(posedge clk);
        #1 check("d4_clr_count", 32'(cnt_b), 32'd0);
        @(negedge clk) clear = 1'b0;
        @(posedge clk);
        #1;
        check("d4_re_we", 32'(we_b), 32'd1);
        check("d4_re_addr", addr_b, BASE);

        @(negedge clk) begin rst = 1'b1; idle_inputs(); end
        @(posedge clk);
        dep = '{1024, 4};
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mbusy[k] = 0; mwe[k] = 0; merr[k] = 0;
            maddr[k] = 0; mword[k] = 0;
        end

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) == 0);
            clear = ($urandom_range(0, 15) == 0);
            valid = ($urandom_range(0, 3) != 0);
            op    = 4'($urandom_range(0, 15));
            rs    = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            imm   = 16'($urandom); tgt = 26'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_rdy = !mbusy[k] && mcnt[k] < dep[k] && !clear && !rst;
                check("rnd_ready",
                      32'(k == 0 ? ifa.in_ready : ifb.in_ready),
                      32'(exp_rdy));
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    mbusy[k] = 0; mwe[k] = 0; mcnt[k] = 0; merr[k] = 0;
                    maddr[k] = 0; mword[k] = 0;
                end else if (mbusy[k]) begin
                    mbusy[k] = 0; mwe[k] = 0;
                    if (clear) begin mcnt[k] = 0; merr[k] = 0; end
                    else mcnt[k]++;
                end else if (clear) begin
                    mwe[k] = 0; mcnt[k] = 0; merr[k] = 0;
                end else if (valid && mcnt[k] < dep[k]) begin
                    if (op <= 4'd12) begin
                        mbusy[k] = 1; mwe[k] = 1;
                        maddr[k] = BASE + 32'(4 * mcnt[k]);
                        mword[k] = ref_word(int'(op), int'(rs), int'(rt),
                                            int'(rd), int'(imm), int'(tgt));
                    end else begin
                        merr[k] = 1;
                    end
                end
            end
            #1;
            check("rnd_we_a", 32'(we_a), 32'(mwe[0]));
            check("rnd_addr_a", addr_a, maddr[0]);
            check("rnd_wd_a", wd_a, mword[0]);
            check("rnd_cnt_a", 32'(cnt_a), 32'(mcnt[0]));
            check("rnd_err_a", 32'(err_a), 32'(merr[0]));
            check("rnd_we_b", 32'(we_b), 32'(mwe[1]));
            check("rnd_addr_b", addr_b, maddr[1]);
            check("rnd_wd_b", wd_b, mword[1]);
            check("rnd_cnt_b", 32'(cnt_b), 32'(mcnt[1]));
            check("rnd_full_b", 32'(full_b), 32'(mcnt[1] == 4));
            check("rnd_err_b", 32'(err_b), 32'(merr[1]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
